sr_simd_shifter: RTL and testbench

Multi-cycle packed-SIMD shift unit that executes 8-bit-lane shift operations (saturating left, arithmetic right, rounding arithmetic right, signed-amount combined shift) on four lanes of a 32-bit operand, one bit position per cycle. It sits beside `sr_alu` in the execute stage as a valid/ready responder. The pipeline issues a shift request and receives the packed result plus a per-operation overflow flag. The unit also keeps a sticky saturation flag, the architectural OV bit, that accumulates every `ov` it reports.

---
 rtl/sr_simd_shifter.sv | 91 +++++++++
 tb/tb_sr_simd_shifter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sr_simd_shifter.sv
// sr_simd_shifter: 4x8-bit packed SIMD shifter, one bit position per cycle, with lane saturation and sticky OV
module sr_simd_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [3:0]  req_amt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_ov,
  output logic        ov_sticky,
  input  logic        ov_clear
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] data, data_nx, fin;
  logic [3:0] sat, sat_nx, rnd, cnt, n;
  logic [1:0] op;
  logic left, dir, accept, last;
  assign accept = req_valid & req_ready;
  assign last = state == SHIFT && cnt == 4'd1;
  assign req_ready = state == IDLE && !rst;
  assign rsp_valid = state == DONE;
  // decode step count and direction of the incoming request
  always_comb begin
    n = req_op == 2'b11 ? (req_amt[3] ? 4'd0 - req_amt : req_amt) : {1'b0, req_amt[2:0]};
    dir = req_op == 2'b00 || (req_op == 2'b11 && !req_amt[3]);
  end
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] l, s;
    assign l = data[8*i +: 8];
    assign s = sat[i] ? l : l[7] != l[6] ? {l[7], {7{l[6]}}} : {l[6:0], 1'b0};
    assign data_nx[8*i +: 8] = left ? s : {l[7], l[7:1]};
    assign sat_nx[i] = sat[i] | (left & (l[7] ^ l[6]));
    assign rnd[i] = l[0];
    assign fin[8*i +: 8] = data_nx[8*i +: 8] + {7'd0, op == 2'b10 && rnd[i]};
  end
  // next-state logic
  always_comb begin
    state_nx = state == IDLE ? (accept ? (n == 4'd0 ? DONE : SHIFT) : IDLE)
             : state == SHIFT ? (cnt == 4'd1 ? DONE : SHIFT)
             : (rsp_ready ? IDLE : DONE);
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // operand capture on accept, one lane step per SHIFT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      op <= '0;
      left <= 1'b0;
      cnt <= '0;
      sat <= '0;
    end else if (accept) begin
      data <= req_a;
      op <= req_op;
      left <= dir;
      cnt <= n;
      sat <= '0;
    end else if (state == SHIFT) begin
      data <= data_nx;
      sat <= sat_nx;
      cnt <= cnt - 4'd1;
    end
  end
  // response registers, loaded only on entry to DONE so they hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_ov <= 1'b0;
    end else if (accept && n == 4'd0) begin
      rsp_result <= req_a;
      rsp_ov <= 1'b0;
    end else if (last) begin
      rsp_result <= fin;
      rsp_ov <= |sat_nx;
    end
  end
  // sticky overflow; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ov_sticky <= 1'b0;
    else if (last && |sat_nx) ov_sticky <= 1'b1;
    else if (ov_clear) ov_sticky <= 1'b0;
  end
endmodule

// File: tb/tb_sr_simd_shifter.sv
// tb_sr_simd_shifter: directed and random checks of sr_simd_shifter against an arithmetic lane model
module tb_sr_simd_shifter;
  logic clk = 0, rst = 1, req_valid = 0, rsp_ready = 0, ov_clear = 0;
  logic [1:0] req_op = 0;
  logic [31:0] req_a = 0;
  logic [3:0] req_amt = 0;
  logic req_ready, rsp_valid, rsp_ov, ov_sticky;
  logic [31:0] rsp_result;
  int n_checks = 0, n_fail = 0;
  logic sticky_m = 0;

  sr_simd_shifter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_amt(req_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_ov(rsp_ov), .ov_sticky(ov_sticky), .ov_clear(ov_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [3:0] amt,
                                output logic [31:0] r, output logic ov, output int n);
    int v, w;
    bit lft;
    n = op == 2'b11 ? (amt[3] ? 16 - int'(amt) : int'(amt)) : int'(amt[2:0]);
    lft = op == 2'b00 || (op == 2'b11 && !amt[3]);
    ov = 0;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      v = $signed(a[8*i +: 8]);
      if (n == 0) w = v;
      else if (lft) begin
        w = v * (1 << n);
        if (w > 127) begin w = 127; ov = 1; end
        else if (w < -128) begin w = -128; ov = 1; end
      end else begin
        w = v >>> n;
        if (op == 2'b10) w += (v >>> (n - 1)) & 1;
      end
      r[8*i +: 8] = w[7:0];
    end
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [3:0] amt, input int hold, input bit clr);
    logic [31:0] er;
    logic eov;
    int n, k, lat;
    model(op, a, amt, er, eov, n);
    @(negedge clk);
    req_valid = 1; req_op = op; req_a = a; req_amt = amt;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    check("accept_wait", k < 50, 1);
    @(negedge clk);
    req_valid = 0; req_a = $urandom; req_op = 2'($urandom); req_amt = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      ov_clear = clr && lat == n;
      @(negedge clk);
      ov_clear = 0;
      lat++;
    end
    check("latency", lat, n == 0 ? 1 : n + 1);
    check("result", rsp_result, er);
    check("ov", rsp_ov, eov);
    sticky_m = sticky_m | eov;
    check("sticky", ov_sticky, sticky_m);
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      check("hold_result", rsp_result, er);
      check("hold_ov", rsp_ov, eov);
      check("hold_handshake", {rsp_valid, req_ready}, 2'b10);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("release", {rsp_valid, req_ready}, 2'b01);
  endtask

  task automatic clear_sticky();
    @(negedge clk); ov_clear = 1;
    @(negedge clk); ov_clear = 0;
    sticky_m = 0;
    check("lone_clear", ov_sticky, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_outputs", {rsp_valid, rsp_ov, ov_sticky}, 3'b000);
    check("rst_result", rsp_result, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);
    do_op(2'b00, 32'h7F4001C0, 4'd1, 0, 0);
    do_op(2'b10, 32'h05FB807F, 4'd1, 0, 0);
    do_op(2'b01, 32'h05FB807F, 4'd1, 0, 0);
    do_op(2'b11, 32'h807F00FF, 4'b1000, 0, 0);
    do_op(2'b11, 32'h00000001, 4'd7, 0, 0);
    for (int op = 0; op < 4; op++) do_op(2'(op), 32'hDEADBEEF, 4'd0, 0, 0);
    do_op(2'b00, 32'h7F4001C0, 4'd1, 5, 0);
    clear_sticky();
    do_op(2'b00, 32'h40000000, 4'd1, 0, 1);
    clear_sticky();
    for (int t = 0; t < 40; t++) do_op(2'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 2)), 0);
    do_op(2'b00, 32'h7F000000, 4'd3, 0, 0);
    @(negedge clk);
    req_valid = 1; req_op = 2'b00; req_a = 32'h00000001; req_amt = 4'd7;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk); @(negedge clk);
    rst = 1;
    #1;
    check("abort_valid", rsp_valid, 0);
    check("abort_sticky", ov_sticky, 0);
    check("abort_result", rsp_result, 0);
    check("abort_ready", req_ready, 0);
    @(negedge clk);
    rst = 0;
    sticky_m = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("no_rsp_after_abort", rsp_valid, 0);
    end
    do_op(2'b11, 32'h12F08001, 4'b1101, 1, 0);
    do_op(2'b10, 32'hC3817F05, 4'd3, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
